vec_load_unit: RTL and testbench
================================

# vec_load_unit

Vector/scalar load engine that gathers 32-bit words from data memory over a single-outstanding req/ack port and commits them to the register file's write port. Feeds the write side (`we3`, `ra3`, `wd3`, `selec_v_s_w`, `cmd`) of the 16-lane vector register file, sitting between the execute stage and data memory. One load in flight at a time; the pipeline stalls on `busy`.

## Interface
- `LANES`, 16, number of vector lanes; lane 15 is the scalar slot
- `DW`, 32, data and element width
- `AW`, 32, byte address width
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — one-cycle command strobe; accepted only in IDLE
- `is_vector` in 1 — 1: 16-element vector load; 0: single scalar word
- `base_addr` in AW — byte address of element 0
- `stride` in AW — byte distance between consecutive elements; ignored for scalar
- `rd_dst` in 4 — destination register index
- `busy` out 1 — high whenever the state is not IDLE
- `done` out 1 — one-cycle pulse, coincident with the register-file write
- `mem_req` out 1 — memory read request
- `mem_addr` out AW — request address, stable while `mem_req` is high
- `mem_ack` in 1 — read completion; `mem_rdata` valid in the same cycle
- `mem_rdata` in DW — read data
- `we3` out 1 — register-file write enable
- `ra3` out 4 — register-file write index
- `wd3` out LANES×DW — packed write data, `wd3[i]` = lane i
- `selec_v_s_w` out 1 — 1: vector write; 0: scalar write
- `cmd` out 3 — always 3'b000; 3'b101 is never driven

## Operation
- FSM states: IDLE, REQ, WRITE. Encoding lives in the package.
- IDLE, `start`=1:
  - latch `is_vector`, `rd_dst`, `stride`
  - load `addr` ← `base_addr` and `idx` ← 0
  - clear the lane buffer to zero
  - go to REQ
- IDLE, `start`=0: stay in IDLE. `mem_ack` is ignored.
- REQ:
  - `mem_req`=1 and `mem_addr`=`addr`, driven from registers
  - on `mem_ack`, capture `mem_rdata` into `buf[idx]` for a vector load, or into `buf[15]` for a scalar load
  - after a capture, finish if the load is scalar or `idx`=15: go to WRITE
  - otherwise `idx`++ and `addr` ← `addr`+`stride`, mod 2^32 (wrap-around, no fault)
  - with no ack, hold `mem_req` and `mem_addr` unchanged
  - acks are counted only in REQ; each ack consumes exactly one element
- WRITE:
  - `we3`=1, `ra3`=`rd_dst`, `wd3`=`buf`, `selec_v_s_w`=`is_vector`, `cmd`=000
  - `done`=1
  - next state is IDLE
- Scalar loads leave lanes 14:0 of `wd3` at zero. The register file ignores those lanes when `selec_v_s_w`=0.
- `start` outside IDLE is ignored: no queueing, no effect on the load in progress.
- Register index 15 is a legal destination. The read-side r15 aliasing belongs to the register file, not this block.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `mem_req`=0, `mem_addr`=0, `we3`=0, `ra3`=0, `wd3`=0, `selec_v_s_w`=0, `cmd`=000, buffer zero.
- `rst` mid-load aborts the load:
  - next cycle is IDLE
  - no write is issued
  - a pending ack is dropped
- Vector latency, `mem_ack` tied high:
  - `start` at cycle T
  - REQ from T+1 to T+16, one element per cycle
  - WRITE at T+17
  - `busy` low at T+18
- Scalar latency, `mem_ack` tied high: WRITE at T+2. Each ack wait state adds one cycle.
- The register file samples on negedge, so the WRITE-cycle outputs are consumed within that same cycle.
- Earliest next `start`: the first IDLE cycle after WRITE. Minimum issue interval is 18 cycles for vector loads and 3 cycles for scalar loads.

## Structure
- Package `vlu_pkg`:
  - state enum `vlu_state_t`
  - `VLU_LANES`=16
  - `CMD_LOAD`=3'b000
  - `SCALAR_LANE`=15
- Single module, no sub-module. The lane buffer is a packed `[15:0][31:0]` register array indexed by `idx`.

## Test plan
- Vector load:
  - stimulus: base 0x100, stride 4, dst 3, ack tied high, memory word = address
  - required: one `we3` pulse at T+17 with `ra3`=3, `selec_v_s_w`=1, `wd3[i]`=0x100+4i
- Scalar load:
  - stimulus: base 0x40, dst 5, memory returns 0xDEADBEEF
  - required: WRITE at T+2 with `selec_v_s_w`=0, `wd3[15]`=0xDEADBEEF, `wd3[14:0]`=0, `done` pulse
- Ack backpressure:
  - stimulus: random 0–3 wait cycles per element
  - required: `mem_addr` stable while waiting, exactly 16 captures in order, WRITE one cycle after the 16th ack
- Address wrap:
  - stimulus: base 0xFFFFFFF8, stride 4
  - required: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, …
- `start` while busy:
  - stimulus: second `start` pulse at T+5
  - required: ignored; exactly one write, with the first command's `rd_dst`
- Reset mid-load:
  - stimulus: `rst` at T+8
  - required: next cycle all outputs at reset values, no `we3`; a subsequent load completes correctly with a zeroed buffer

Source files
------------

// File: rtl/vlu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vlu_pkg
//  Description : Shared types and constants for the vector/scalar load unit:
//                FSM state encoding, lane count, register-file command code
//                and the lane that carries a scalar result.
//  Revision    : 1.0  initial release
// ============================================================================
package vlu_pkg;

    // Number of vector lanes in the register file.
    localparam int VLU_LANES = 16;

    // Register-file command for a plain load write. 3'b101 is never issued.
    localparam logic [2:0] CMD_LOAD = 3'b000;

    // Lane that receives the single word of a scalar load.
    localparam int SCALAR_LANE = 15;

    // Load-unit FSM states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } vlu_state_t;

    // Buffer lane that a captured word lands in: the running element index
    // for a vector load, the scalar slot otherwise.
    function automatic logic [3:0] capture_lane(input logic is_vec, input logic [3:0] idx);
        return is_vec ? idx : 4'(SCALAR_LANE);
    endfunction

endpackage : vlu_pkg
`default_nettype wire

// File: rtl/vec_load_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vec_load_unit
//  Description : Gathers 32-bit words from data memory over a single
//                outstanding req/ack port (one element per ack) and commits
//                the assembled vector, or a single scalar word in lane 15,
//                to the write port of the 16-lane vector register file.
//  Revision    : 1.0  initial release
// ============================================================================
module vec_load_unit
    import vlu_pkg::*;
#(
    parameter int LANES = VLU_LANES,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // Command side (execute stage)
    input  logic                  start,
    input  logic                  is_vector,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         stride,
    input  logic [3:0]            rd_dst,
    output logic                  busy,
    output logic                  done,

    // Data-memory read port
    output logic                  mem_req,
    output logic [AW-1:0]         mem_addr,
    input  logic                  mem_ack,
    input  logic [DW-1:0]         mem_rdata,

    // Register-file write port
    output logic                  we3,
    output logic [3:0]            ra3,
    output logic [LANES*DW-1:0]   wd3,
    output logic                  selec_v_s_w,
    output logic [2:0]            cmd
);

    localparam int IW = $clog2(LANES);

    // Control state and per-command context latched at start.
    vlu_state_t                 state;
    logic                       vec_q;
    logic [3:0]                 dst_q;
    logic [AW-1:0]              stride_q;
    logic [AW-1:0]              addr;
    logic [IW-1:0]              idx;

    // Assembled write data, one DW-bit word per lane.
    logic [LANES-1:0][DW-1:0]   lane_buf;

    // A capture ends the load on the only scalar word or the last vector lane.
    logic                       last_elem;
    assign last_elem = !vec_q || (idx == IW'(LANES - 1));

    // FSM, address generation, element capture; reset aborts any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            vec_q    <= 1'b0;
            dst_q    <= 4'd0;
            stride_q <= '0;
            addr     <= '0;
            idx      <= '0;
            lane_buf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Acks arriving here belong to nothing and are ignored.
                    if (start) begin
                        vec_q    <= is_vector;
                        dst_q    <= rd_dst;
                        stride_q <= stride;
                        addr     <= base_addr;
                        idx      <= '0;
                        lane_buf <= '0;
                        state    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // Request and address hold steady until the ack arrives.
                    if (mem_ack) begin
                        lane_buf[capture_lane(vec_q, idx)] <= mem_rdata;
                        if (last_elem) begin
                            state <= ST_WRITE;
                        end else begin
                            idx  <= idx + 1'b1;
                            // Wraps modulo 2^AW by construction.
                            addr <= addr + stride_q;
                        end
                    end
                end

                ST_WRITE: begin
                    // The register file consumes the write within this cycle.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded directly from registered state and context.
    assign busy        = (state != ST_IDLE);
    assign mem_req     = (state == ST_REQ);
    assign mem_addr    = addr;
    assign we3         = (state == ST_WRITE);
    assign done        = (state == ST_WRITE);
    assign ra3         = dst_q;
    assign wd3         = lane_buf;
    assign selec_v_s_w = vec_q;
    assign cmd         = CMD_LOAD;

endmodule : vec_load_unit
`default_nettype wire

// File: tb/tb_vec_load_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_load_unit
//  Description : Directed self-checking bench for vec_load_unit: reset state,
//                vector and scalar loads, ack backpressure, address wrap,
//                start while busy and reset mid-load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vec_load_unit;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 is_vector;
    logic [AW-1:0]        base_addr;
    logic [AW-1:0]        stride;
    logic [3:0]           rd_dst;
    logic                 busy;
    logic                 done;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_ack;
    logic [DW-1:0]        mem_rdata;
    logic                 we3;
    logic [3:0]           ra3;
    logic [LANES*DW-1:0]  wd3;
    logic                 selec_v_s_w;
    logic [2:0]           cmd;

    // Memory model controls: either a fixed word or address XOR a pattern.
    logic                 fixed_mode;
    logic [DW-1:0]        fixed_word;
    logic [DW-1:0]        data_xor;

    int passed = 0;
    int total  = 0;
    int we3_cnt;
    logic [LANES*DW-1:0]  exp_wd;
    logic [AW-1:0]        exp_addr;
    logic [AW-1:0]        wrap_tab [4];

    vec_load_unit #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_vector   (is_vector),
        .base_addr   (base_addr),
        .stride      (stride),
        .rd_dst      (rd_dst),
        .busy        (busy),
        .done        (done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .we3         (we3),
        .ra3         (ra3),
        .wd3         (wd3),
        .selec_v_s_w (selec_v_s_w),
        .cmd         (cmd)
    );

    always #5 clk = ~clk;

    // Memory returns data combinationally for the presented address.
    always_comb begin
        mem_rdata = fixed_mode ? fixed_word : (mem_addr ^ data_xor);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string ctx);
        check({ctx, "_busy"},    512'(busy),        512'(0));
        check({ctx, "_done"},    512'(done),        512'(0));
        check({ctx, "_mem_req"}, 512'(mem_req),     512'(0));
        check({ctx, "_mem_addr"},512'(mem_addr),    512'(0));
        check({ctx, "_we3"},     512'(we3),         512'(0));
        check({ctx, "_ra3"},     512'(ra3),         512'(0));
        check({ctx, "_wd3"},     512'(wd3),         512'(0));
        check({ctx, "_selec"},   512'(selec_v_s_w), 512'(0));
        check({ctx, "_cmd"},     512'(cmd),         512'(0));
    endtask

    // Presents a one-cycle start; returns in the first cycle after it (T+1).
    task automatic start_load(input logic vec, input logic [AW-1:0] base,
                              input logic [AW-1:0] str, input logic [3:0] dst);
        start     = 1'b1;
        is_vector = vec;
        base_addr = base;
        stride    = str;
        rd_dst    = dst;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        is_vector  = 1'b0;
        base_addr  = '0;
        stride     = '0;
        rd_dst     = '0;
        mem_ack    = 1'b0;
        fixed_mode = 1'b0;
        fixed_word = '0;
        data_xor   = '0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Acks while idle must not start anything.
        mem_ack = 1'b1;
        tick();
        tick();
        check("idle_ack_busy", 512'(busy), 512'(0));
        check("idle_ack_req",  512'(mem_req), 512'(0));

        // Vector load: base 0x100, stride 4, dst 3, data = address.
        for (int i = 0; i < LANES; i++) exp_wd[i*DW +: DW] = 32'h100 + 32'(4 * i);
        start_load(1'b1, 32'h100, 32'd4, 4'd3);
        check("vec_busy", 512'(busy), 512'(1));
        we3_cnt = 0;
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("vec_req_%0d", k),  512'(mem_req),  512'(1));
            check($sformatf("vec_addr_%0d", k), 512'(mem_addr), 512'(32'h100 + 32'(4 * k)));
            if (we3) we3_cnt++;
            tick();
        end
        check("vec_early_we3", 512'(we3_cnt), 512'(0));
        check("vec_we3",   512'(we3),         512'(1));
        check("vec_done",  512'(done),        512'(1));
        check("vec_ra3",   512'(ra3),         512'(3));
        check("vec_selec", 512'(selec_v_s_w), 512'(1));
        check("vec_cmd",   512'(cmd),         512'(0));
        check("vec_wd3",   512'(wd3),         512'(exp_wd));
        tick();
        check("vec_idle_busy", 512'(busy), 512'(0));
        check("vec_idle_we3",  512'(we3),  512'(0));

        // Scalar load: base 0x40, dst 5, memory returns 0xDEADBEEF.
        fixed_mode = 1'b1;
        fixed_word = 32'hDEAD_BEEF;
        start_load(1'b0, 32'h40, 32'h1234, 4'd5);
        check("sc_req",  512'(mem_req),  512'(1));
        check("sc_addr", 512'(mem_addr), 512'(32'h40));
        check("sc_we3_early", 512'(we3), 512'(0));
        tick();
        exp_wd = '0;
        exp_wd[15*DW +: DW] = 32'hDEAD_BEEF;
        check("sc_we3",   512'(we3),         512'(1));
        check("sc_done",  512'(done),        512'(1));
        check("sc_ra3",   512'(ra3),         512'(5));
        check("sc_selec", 512'(selec_v_s_w), 512'(0));
        check("sc_wd3",   512'(wd3),         512'(exp_wd));
        tick();
        check("sc_idle_busy", 512'(busy), 512'(0));

        // Backpressure: k%4 wait cycles before each element's ack.
        fixed_mode = 1'b0;
        data_xor   = 32'hA5A5_0000;
        mem_ack    = 1'b0;
        for (int i = 0; i < LANES; i++) exp_wd[i*DW +: DW] = (32'h200 + 32'(8 * i)) ^ 32'hA5A5_0000;
        start_load(1'b1, 32'h200, 32'd8, 4'd7);
        we3_cnt = 0;
        for (int k = 0; k < LANES; k++) begin
            for (int w = 0; w < (k % 4); w++) begin
                mem_ack = 1'b0;
                check($sformatf("bp_wait_req_%0d_%0d", k, w),  512'(mem_req),  512'(1));
                check($sformatf("bp_wait_addr_%0d_%0d", k, w), 512'(mem_addr), 512'(32'h200 + 32'(8 * k)));
                if (we3) we3_cnt++;
                tick();
            end
            mem_ack = 1'b1;
            check($sformatf("bp_ack_addr_%0d", k), 512'(mem_addr), 512'(32'h200 + 32'(8 * k)));
            if (we3) we3_cnt++;
            tick();
        end
        mem_ack = 1'b0;
        check("bp_early_we3", 512'(we3_cnt), 512'(0));
        check("bp_we3", 512'(we3), 512'(1));
        check("bp_ra3", 512'(ra3), 512'(7));
        check("bp_wd3", 512'(wd3), 512'(exp_wd));
        tick();
        check("bp_idle_busy", 512'(busy), 512'(0));

        // Address wrap: base 0xFFFFFFF8, stride 4.
        data_xor    = '0;
        mem_ack     = 1'b1;
        wrap_tab[0] = 32'hFFFF_FFF8;
        wrap_tab[1] = 32'hFFFF_FFFC;
        wrap_tab[2] = 32'h0000_0000;
        wrap_tab[3] = 32'h0000_0004;
        for (int i = 0; i < LANES; i++) begin
            exp_addr = 32'hFFFF_FFF8 + 32'(4 * i);
            exp_wd[i*DW +: DW] = exp_addr;
        end
        start_load(1'b1, 32'hFFFF_FFF8, 32'd4, 4'd9);
        for (int k = 0; k < LANES; k++) begin
            if (k < 4) check($sformatf("wrap_addr_%0d", k), 512'(mem_addr), 512'(wrap_tab[k]));
            tick();
        end
        check("wrap_we3", 512'(we3), 512'(1));
        check("wrap_wd3", 512'(wd3), 512'(exp_wd));
        tick();

        // Second start at T+5 must be ignored.
        start_load(1'b1, 32'h300, 32'd4, 4'd2);
        we3_cnt = 0;
        for (int k = 1; k <= LANES; k++) begin
            if (k == 5) begin
                start     = 1'b1;
                is_vector = 1'b0;
                rd_dst    = 4'd11;
                base_addr = 32'h999;
            end else begin
                start = 1'b0;
            end
            if (k == 6) check("busy_start_addr", 512'(mem_addr), 512'(32'h314));
            if (we3) we3_cnt++;
            tick();
        end
        start = 1'b0;
        check("busy_start_we3",   512'(we3),         512'(1));
        check("busy_start_ra3",   512'(ra3),         512'(2));
        check("busy_start_selec", 512'(selec_v_s_w), 512'(1));
        for (int k = 0; k < 4; k++) begin
            if (we3) we3_cnt++;
            tick();
        end
        check("busy_start_write_count", 512'(we3_cnt), 512'(1));
        check("busy_start_idle", 512'(busy), 512'(0));

        // Reset asserted at T+8 of a vector load.
        start_load(1'b1, 32'h500, 32'd4, 4'd4);
        we3_cnt = 0;
        for (int k = 1; k < 8; k++) begin
            if (we3) we3_cnt++;
            tick();
        end
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (we3) we3_cnt++;
            tick();
        end
        check("midrst_no_write", 512'(we3_cnt), 512'(0));
        check("midrst_idle",     512'(busy),    512'(0));

        // A subsequent load completes on a zeroed buffer.
        fixed_mode = 1'b1;
        fixed_word = 32'h1234_5678;
        start_load(1'b0, 32'h80, 32'd4, 4'd6);
        check("post_addr", 512'(mem_addr), 512'(32'h80));
        tick();
        exp_wd = '0;
        exp_wd[15*DW +: DW] = 32'h1234_5678;
        check("post_we3", 512'(we3), 512'(1));
        check("post_ra3", 512'(ra3), 512'(6));
        check("post_wd3", 512'(wd3), 512'(exp_wd));
        tick();
        check("post_idle", 512'(busy), 512'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_vec_load_unit
`default_nettype wire
